// File: rtl/fifo_param.sv
// fifo_param: parametrised multi-entry FIFO with enq/deq/first handshakes.
// Ready signals are derived from the occupancy counter: producers stall
// when full and consumers stall when empty.
// Optional macro FIFO_STATUS_EN exposes out_count and out_almost_full.
module fifo_param #(
    parameter int WIDTH       = 128,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_enq__ENA,
    input  logic [WIDTH-1:0] in_enq_v,
    output logic             in_enq__RDY,
    input  logic             out_deq__ENA,
    output logic             out_deq__RDY,
    output logic [WIDTH-1:0] out_first,
    output logic             out_first__RDY
`ifdef FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] out_count,
    output logic                       out_almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = CW'(0);

    // Reject unusable configurations at elaboration time.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_LEVEL < 0 || AFULL_LEVEL > DEPTH)
    begin : g_param_check
        $error("fifo_param: DEPTH must be a power of two >= 2 and 0 <= AFULL_LEVEL <= DEPTH");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             enq_fire_s;
    logic             deq_fire_s;
    logic             not_full_s;
    logic             not_empty_s;

    // Ready flags come straight from the count register, so there is no
    // combinational path from any ENA input to any RDY output.
    assign not_full_s     = (count_r != CNT_FULL);
    assign not_empty_s    = (count_r != CNT_EMPTY);
    assign in_enq__RDY    = not_full_s;
    assign out_deq__RDY   = not_empty_s;
    assign out_first__RDY = not_empty_s;

    // An ENA without its matching RDY is silently dropped.
    assign enq_fire_s = in_enq__ENA & not_full_s;
    assign deq_fire_s = out_deq__ENA & not_empty_s;

    // Head entry is read directly from storage; stale when empty.
    assign out_first = mem_r[rd_ptr_r];

    // Next occupancy: simultaneous enq and deq cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({enq_fire_s, deq_fire_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            2'b11:   count_next_s = count_r;
            default: count_next_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; reset wins over any same-cycle ENA.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
        end
    end

    // Storage array; cleared on reset so out_first reads 0 afterwards.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (enq_fire_s) begin
            mem_r[wr_ptr_r] <= in_enq_v;
        end
    end

`ifdef FIFO_STATUS_EN
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

    assign out_count       = count_r;
    assign out_almost_full = (count_r >= AFULL_CNT);
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (DEPTH=4, WIDTH=128).
// Status-port checks are compiled in only when FIFO_STATUS_EN is defined.
module tb_fifo_param;

    localparam int WIDTH = 128;
    localparam int DEPTH = 4;

    logic             CLK;
    logic             RST;
    logic             enq_ena;
    logic [WIDTH-1:0] enq_v;
    logic             enq_rdy;
    logic             deq_ena;
    logic             deq_rdy;
    logic [WIDTH-1:0] first;
    logic             first_rdy;
`ifdef FIFO_STATUS_EN
    logic [2:0]       count;
    logic             afull;
`endif

    int n_cmp;
    int n_fail;

    fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .in_enq__ENA    (enq_ena),
        .in_enq_v       (enq_v),
        .in_enq__RDY    (enq_rdy),
        .out_deq__ENA   (deq_ena),
        .out_deq__RDY   (deq_rdy),
        .out_first      (first),
        .out_first__RDY (first_rdy)
`ifdef FIFO_STATUS_EN
        ,
        .out_count      (count),
        .out_almost_full(afull)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock cycle with the given request pattern; outputs settle #1 later.
    task automatic cyc(input logic rst, input logic e, input logic [WIDTH-1:0] v, input logic d);
        RST = rst; enq_ena = e; enq_v = v; deq_ena = d;
        @(posedge CLK);
        #1;
        RST = 1'b0; enq_ena = 1'b0; deq_ena = 1'b0; enq_v = '0;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        n_cmp++; if (enq_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_enq_rdy: got %b want 1", enq_rdy); end
        n_cmp++; if (first_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_first_rdy: got %b want 0", first_rdy); end
        n_cmp++; if (deq_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_deq_rdy: got %b want 0", deq_rdy); end
        n_cmp++; if (first !== 128'h0) begin n_fail++; $display("FAIL reset_first: got %0h want 0", first); end
`ifdef FIFO_STATUS_EN
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b want 0", afull); end
`endif
    endtask

    task automatic test_fill();
        cyc(1'b0, 1'b1, 128'h11, 1'b0);
        n_cmp++; if (first_rdy !== 1'b1) begin n_fail++; $display("FAIL fill_first_rdy: got %b want 1", first_rdy); end
        n_cmp++; if (first !== 128'h11) begin n_fail++; $display("FAIL fill_first_latency: got %0h want 11", first); end
        cyc(1'b0, 1'b1, 128'h22, 1'b0);
        cyc(1'b0, 1'b1, 128'h33, 1'b0);
        n_cmp++; if (enq_rdy !== 1'b1) begin n_fail++; $display("FAIL fill_enq_rdy_3: got %b want 1", enq_rdy); end
`ifdef FIFO_STATUS_EN
        n_cmp++; if (afull !== 1'b1) begin n_fail++; $display("FAIL fill_afull_3: got %b want 1", afull); end
`endif
        cyc(1'b0, 1'b1, 128'h44, 1'b0);
        n_cmp++; if (enq_rdy !== 1'b0) begin n_fail++; $display("FAIL full_enq_rdy: got %b want 0", enq_rdy); end
        n_cmp++; if (deq_rdy !== 1'b1) begin n_fail++; $display("FAIL full_deq_rdy: got %b want 1", deq_rdy); end
`ifdef FIFO_STATUS_EN
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
        n_cmp++; if (afull !== 1'b1) begin n_fail++; $display("FAIL full_afull: got %b want 1", afull); end
`endif
        cyc(1'b0, 1'b1, 128'h55, 1'b0);
        n_cmp++; if (enq_rdy !== 1'b0) begin n_fail++; $display("FAIL overfill_enq_rdy: got %b want 0", enq_rdy); end
        n_cmp++; if (first !== 128'h11) begin n_fail++; $display("FAIL overfill_first: got %0h want 11", first); end
`ifdef FIFO_STATUS_EN
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL overfill_count: got %0d want 4", count); end
`endif
    endtask

    task automatic test_drain();
        logic [WIDTH-1:0] exp_q [4];
        exp_q[0] = 128'h11; exp_q[1] = 128'h22; exp_q[2] = 128'h33; exp_q[3] = 128'h44;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (first !== exp_q[i]) begin n_fail++; $display("FAIL drain_order[%0d]: got %0h want %0h", i, first, exp_q[i]); end
            cyc(1'b0, 1'b0, '0, 1'b1);
        end
        n_cmp++; if (deq_rdy !== 1'b0) begin n_fail++; $display("FAIL drain_deq_rdy: got %b want 0", deq_rdy); end
        n_cmp++; if (enq_rdy !== 1'b1) begin n_fail++; $display("FAIL drain_enq_rdy: got %b want 1", enq_rdy); end
`ifdef FIFO_STATUS_EN
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
`endif
        // Extra deq while empty: nothing moves, stale head at slot 0 is 0x11.
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (first_rdy !== 1'b0) begin n_fail++; $display("FAIL underflow_first_rdy: got %b want 0", first_rdy); end
        n_cmp++; if (first !== 128'h11) begin n_fail++; $display("FAIL underflow_stale_first: got %0h want 11", first); end
`ifdef FIFO_STATUS_EN
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL underflow_count: got %0d want 0", count); end
`endif
    endtask

    task automatic test_concurrent();
        cyc(1'b0, 1'b1, 128'hA, 1'b0);
        cyc(1'b0, 1'b1, 128'hB, 1'b0);
        cyc(1'b0, 1'b1, 128'hC, 1'b1);
        n_cmp++; if (first !== 128'hB) begin n_fail++; $display("FAIL conc_first: got %0h want b", first); end
        n_cmp++; if (enq_rdy !== 1'b1) begin n_fail++; $display("FAIL conc_enq_rdy: got %b want 1", enq_rdy); end
`ifdef FIFO_STATUS_EN
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL conc_count: got %0d want 2", count); end
`endif
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (first !== 128'hC) begin n_fail++; $display("FAIL conc_next_head: got %0h want c", first); end
        n_cmp++; if (first_rdy !== 1'b1) begin n_fail++; $display("FAIL conc_first_rdy: got %b want 1", first_rdy); end
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (deq_rdy !== 1'b0) begin n_fail++; $display("FAIL conc_empty: got %b want 0", deq_rdy); end
    endtask

    task automatic test_corners();
        cyc(1'b0, 1'b1, 128'h41, 1'b0);
        cyc(1'b0, 1'b1, 128'h42, 1'b0);
        cyc(1'b0, 1'b1, 128'h43, 1'b0);
        cyc(1'b0, 1'b1, 128'h44, 1'b0);
        // Full: enq+deq performs only the deq; 0x99 is dropped.
        cyc(1'b0, 1'b1, 128'h99, 1'b1);
        n_cmp++; if (enq_rdy !== 1'b1) begin n_fail++; $display("FAIL fullcorner_enq_rdy: got %b want 1", enq_rdy); end
        n_cmp++; if (first !== 128'h42) begin n_fail++; $display("FAIL fullcorner_first: got %0h want 42", first); end
`ifdef FIFO_STATUS_EN
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL fullcorner_count: got %0d want 3", count); end
`endif
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (first !== 128'h44) begin n_fail++; $display("FAIL fullcorner_tail: got %0h want 44", first); end
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (deq_rdy !== 1'b0) begin n_fail++; $display("FAIL fullcorner_drained: got %b want 0", deq_rdy); end
        // Empty: enq+deq performs only the enq.
        cyc(1'b0, 1'b1, 128'h77, 1'b1);
        n_cmp++; if (first_rdy !== 1'b1) begin n_fail++; $display("FAIL emptycorner_first_rdy: got %b want 1", first_rdy); end
        n_cmp++; if (first !== 128'h77) begin n_fail++; $display("FAIL emptycorner_first: got %0h want 77", first); end
`ifdef FIFO_STATUS_EN
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL emptycorner_count: got %0d want 1", count); end
`endif
        cyc(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] v;
        // Prime with 1, then each enq+deq cycle pushes i and pops i-1.
        v = 128'd1;
        cyc(1'b0, 1'b1, v, 1'b0);
        for (int i = 2; i <= 10; i++) begin
            v = WIDTH'(i - 1);
            n_cmp++; if (first !== v) begin n_fail++; $display("FAIL wrap_order[%0d]: got %0h want %0h", i - 1, first, v); end
            v = WIDTH'(i);
            if (i % 2 == 0) begin
                cyc(1'b0, 1'b1, v, 1'b1);
            end else begin
                cyc(1'b0, 1'b1, v, 1'b0);
                cyc(1'b0, 1'b0, '0, 1'b1);
            end
        end
        n_cmp++; if (first !== 128'd10) begin n_fail++; $display("FAIL wrap_order[10]: got %0h want a", first); end
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (deq_rdy !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b want 0", deq_rdy); end
    endtask

    task automatic test_reset_mid();
        cyc(1'b0, 1'b1, 128'h61, 1'b0);
        cyc(1'b0, 1'b1, 128'h62, 1'b0);
        cyc(1'b0, 1'b1, 128'h63, 1'b0);
        cyc(1'b1, 1'b1, 128'h64, 1'b0);
        n_cmp++; if (first_rdy !== 1'b0) begin n_fail++; $display("FAIL midreset_first_rdy: got %b want 0", first_rdy); end
        n_cmp++; if (first !== 128'h0) begin n_fail++; $display("FAIL midreset_first: got %0h want 0", first); end
        n_cmp++; if (enq_rdy !== 1'b1) begin n_fail++; $display("FAIL midreset_enq_rdy: got %b want 1", enq_rdy); end
`ifdef FIFO_STATUS_EN
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", count); end
`endif
        cyc(1'b0, 1'b1, 128'h65, 1'b0);
        n_cmp++; if (first !== 128'h65) begin n_fail++; $display("FAIL midreset_after: got %0h want 65", first); end
        cyc(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (deq_rdy !== 1'b0) begin n_fail++; $display("FAIL midreset_single: got %b want 0", deq_rdy); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        RST = 1'b1; enq_ena = 1'b0; enq_v = '0; deq_ena = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_concurrent();
        test_corners();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
